pong_ctrl: RTL and testbench
============================

# pong_ctrl

Game-sequencing controller for the Pong design. Once per video frame, on a start-of-vertical-blanking tick from the VGA timing block, it runs a fixed 3-cycle update of paddle positions, ball motion, collisions and score. Its position and score outputs feed the pixel renderer that drives RGB to the VGA block. The outputs change only during the update sequence, so they stay constant for the whole visible frame.

## Interface
Parameters:
- SCR_W, 640, active pixels per line
- SCR_H, 480, active lines per frame
- BALL_SIZE, 8, ball edge length in pixels (square ball)
- PAD_W, 8, paddle width
- PAD_H, 64, paddle height
- PAD_L_X, 16, left paddle left-edge x
- PAD_R_X, 616, right paddle left-edge x
- PAD_SPEED, 4, paddle pixels per frame
- BALL_SPEED, 2, ball pixels per frame, per axis
- SERVE_FRAMES, 60, frames the ball is held at center before play
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  system clock (pixel clock domain)
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  1-cycle pulse at the start of vertical blanking
- serve  in  1  1-cycle start/restart request
- l_up, l_dn, r_up, r_dn  in  1 each  paddle buttons, synchronised and level-sensitive
- ball_x, ball_y  out  10  ball top-left corner
- pad_l_y, pad_r_y  out  10  paddle top edges
- score_l, score_r  out  4 each  scores
- state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3
- upd_done  out  1  1-cycle pulse when an update completes

## Operation
- Reset values:
  - ball_x=316, ball_y=236
  - pad_l_y=pad_r_y=208
  - scores 0
  - state IDLE
  - direction dx=+1 (right), dy=+1 (down)
  - upd_done=0
  - serve counter 0
- IDLE: `serve` moves to SERVE. Paddles and ball are frozen (see Configuration).
- SERVE:
  - Ball is held at (316,236); paddles move.
  - Each frame_tick increments the serve counter.
  - When the count reaches SERVE_FRAMES: clear the counter and go to PLAY.
- PLAY, per update:
  - Paddles: `up` subtracts PAD_SPEED; `dn` adds PAD_SPEED.
  - Paddle position is clamped to [0, SCR_H-PAD_H] = [0, 416].
  - If up and dn are asserted together, the paddle does not move.
  - Ball: x and y each move BALL_SPEED in direction dx, dy. Arithmetic is 11-bit signed.
  - Top/bottom walls: if next y < 0, y=0 and dy=+1. If next y > 472, y=472 and dy=-1.
- Left paddle hit, checked only when dx=-1. The hit condition is all of:
  - ball_x ≤ PAD_L_X+PAD_W
  - ball_x+BALL_SIZE > PAD_L_X
  - ball_y+BALL_SIZE > pad_l_y
  - ball_y < pad_l_y+PAD_H
  - On hit: ball_x=PAD_L_X+PAD_W (24) and dx=+1.
- Right paddle hit: mirror of the left case. Checked only when dx=+1. On hit, ball_x=PAD_R_X-BALL_SIZE (608) and dx=-1.
- Miss:
  - next x < 0 → score_r+1. next x > SCR_W-BALL_SIZE (632) → score_l+1.
  - After a miss: recenter the ball, set dx toward the scorer's opponent, and go to SERVE.
  - If the new score equals WIN_SCORE, go to OVER instead of SERVE.
- OVER: positions and scores hold. `serve` clears both scores and goes to SERVE.
- Decisions use paddle positions already updated in the same frame. Paddle collision takes priority over a miss.

## Timing
- frame_tick is sampled at edge T0.
- Update phases:
  - T1: paddle outputs update.
  - T2: ball move and wall clamp.
  - T3: paddle collision, miss handling, score update and state change.
  - upd_done is high during the cycle after T3.
- Worst-case latency from frame_tick to final outputs is 3 cycles. Outputs are otherwise stable.
- frame_tick arriving while an update is in progress (T1–T3) is ignored.
- `serve` is honored only in IDLE or OVER. It is ignored in any other state, including mid-update.
- frame_tick and `serve` in the same cycle in IDLE: `serve` wins. The tick is not counted.
- Reset asserted mid-update aborts the update immediately. All outputs return to their reset values.

## Configuration
- PONG_ATTRACT_EN defined:
  - In IDLE and OVER, the ball moves every frame_tick and bounces off all four walls: x is clamped to [0,632] and dx is reflected, the same way as y.
  - There is no scoring and no paddle interaction.
  - On the transition to SERVE, the ball is recentered.
- Without it: the ball is frozen in IDLE and OVER.

## Test plan
- Reset → all outputs at their reset values. Then `serve` → state=1. After 60 frame_ticks → state=2, and ball_x=318, ball_y=238 after the next update.
- l_up held 60 frames in PLAY → pad_l_y=0 and stays 0. l_up and l_dn together → pad_l_y unchanged.
- Ball at y=472, dy=+1 on frame_tick → y=472, dy=-1; the next frame gives y=470.
- Ball heading left, aligned with pad_l_y → ball_x=24 and dx=+1. Paddle moved away → score_r increments, state=1, ball recentered.
- score_l=8 followed by a right miss → score_l=9 and state=3. `serve` → both scores 0, state=1.
- frame_tick at T0 and T2 → exactly one upd_done pulse. Reset at T2 → reset values at the next cycle.

Source files
------------

// File: rtl/pong_ctrl.sv
// Pong game sequencer: runs a three-phase update (paddles, ball, collisions/score) per frame_tick.
// Build option PONG_ATTRACT_EN: the ball bounces around all four walls while in IDLE and OVER.
module pong_ctrl #(
    parameter int unsigned SCR_W        = 640,
    parameter int unsigned SCR_H        = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PAD_W        = 8,
    parameter int unsigned PAD_H        = 64,
    parameter int unsigned PAD_L_X      = 16,
    parameter int unsigned PAD_R_X      = 616,
    parameter int unsigned PAD_SPEED    = 4,
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       frame_tick_i,
    input  logic       serve_i,
    input  logic       l_up_i,
    input  logic       l_dn_i,
    input  logic       r_up_i,
    input  logic       r_dn_i,
    output logic [9:0] ball_x_o,
    output logic [9:0] ball_y_o,
    output logic [9:0] pad_l_y_o,
    output logic [9:0] pad_r_y_o,
    output logic [3:0] score_l_o,
    output logic [3:0] score_r_o,
    output logic [1:0] state_o,
    output logic       upd_done_o
);
    localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);

    localparam logic signed [10:0] CenX    = 11'((SCR_W - BALL_SIZE) / 2);
    localparam logic signed [10:0] CenY    = 11'((SCR_H - BALL_SIZE) / 2);
    localparam logic signed [10:0] MaxX    = 11'(SCR_W - BALL_SIZE);
    localparam logic signed [10:0] MaxY    = 11'(SCR_H - BALL_SIZE);
    localparam logic signed [10:0] PadMax  = 11'(SCR_H - PAD_H);
    localparam logic [9:0]         PadRst  = 10'((SCR_H - PAD_H) / 2);
    localparam logic signed [10:0] PadSpd  = 11'(PAD_SPEED);
    localparam logic signed [10:0] BallSpd = 11'(BALL_SPEED);
    localparam logic signed [10:0] Size    = 11'(BALL_SIZE);
    localparam logic signed [10:0] PadH    = 11'(PAD_H);
    localparam logic signed [10:0] LX      = 11'(PAD_L_X);
    localparam logic signed [10:0] LHitX   = 11'(PAD_L_X + PAD_W);
    localparam logic signed [10:0] RX      = 11'(PAD_R_X);
    localparam logic signed [10:0] RBackX  = 11'(PAD_R_X + PAD_W);
    localparam logic signed [10:0] RHitX   = 11'(PAD_R_X - BALL_SIZE);
    localparam logic [3:0]         WinS    = 4'(WIN_SCORE);

    typedef enum logic [1:0] {StIdle = 2'd0, StServe = 2'd1, StPlay = 2'd2, StOver = 2'd3} game_st_e;
    typedef enum logic [1:0] {PhWait, PhPad, PhBall, PhHit} phase_e;

    game_st_e           st_q;
    phase_e             ph_q;
    logic signed [10:0] bx_q, by_q;
    logic [9:0]         pl_q, pr_q;
    logic               dx_q, dy_q;  // 1 = moving right / down
    logic [3:0]         sl_q, sr_q;
    logic [CntW-1:0]    cnt_q;
    logic               upd_done_q;

    logic signed [10:0] pl_s, pr_s, bx_mv, by_mv, by_nx;
    logic               dy_nx, hit_l, hit_r;
`ifdef PONG_ATTRACT_EN
    logic signed [10:0] bx_nx;
    logic               dx_nx;
`endif

    function automatic logic [9:0] pad_next(input logic [9:0] p, input logic up, input logic dn);
        logic signed [10:0] t;
        t = $signed({1'b0, p});
        if (up && !dn) begin
            t = t - PadSpd;
        end else if (dn && !up) begin
            t = t + PadSpd;
        end
        if (t[10]) begin
            t = '0;
        end else if (t > PadMax) begin
            t = PadMax;
        end
        return t[9:0];
    endfunction

    always_comb begin
        pl_s  = $signed({1'b0, pl_q});
        pr_s  = $signed({1'b0, pr_q});
        bx_mv = dx_q ? bx_q + BallSpd : bx_q - BallSpd;
        by_mv = dy_q ? by_q + BallSpd : by_q - BallSpd;
        by_nx = by_mv;
        dy_nx = dy_q;
        if (by_mv[10]) begin
            by_nx = '0;
            dy_nx = 1'b1;
        end else if (by_mv > MaxY) begin
            by_nx = MaxY;
            dy_nx = 1'b0;
        end
`ifdef PONG_ATTRACT_EN
        bx_nx = bx_mv;
        dx_nx = dx_q;
        if (bx_mv[10]) begin
            bx_nx = '0;
            dx_nx = 1'b1;
        end else if (bx_mv > MaxX) begin
            bx_nx = MaxX;
            dx_nx = 1'b0;
        end
`endif
        // Evaluated on the post-move ball and post-move paddles of this frame
        hit_l = !dx_q && (bx_q <= LHitX) && (bx_q + Size > LX)
                && (by_q + Size > pl_s) && (by_q < pl_s + PadH);
        hit_r = dx_q && (bx_q + Size >= RX) && (bx_q < RBackX)
                && (by_q + Size > pr_s) && (by_q < pr_s + PadH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q       <= StIdle;
            ph_q       <= PhWait;
            bx_q       <= CenX;
            by_q       <= CenY;
            pl_q       <= PadRst;
            pr_q       <= PadRst;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            sl_q       <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            upd_done_q <= 1'b0;
        end else begin
            upd_done_q <= 1'b0;
            unique case (ph_q)
                PhWait: begin
                    // serve outranks a coincident tick, which is then dropped
                    if (serve_i && (st_q == StIdle || st_q == StOver)) begin
                        st_q  <= StServe;
                        cnt_q <= '0;
                        bx_q  <= CenX;
                        by_q  <= CenY;
                        if (st_q == StOver) begin
                            sl_q <= '0;
                            sr_q <= '0;
                        end
                    end else if (frame_tick_i) begin
                        ph_q <= PhPad;
                    end
                end
                PhPad: begin
                    if (st_q == StServe || st_q == StPlay) begin
                        pl_q <= pad_next(pl_q, l_up_i, l_dn_i);
                        pr_q <= pad_next(pr_q, r_up_i, r_dn_i);
                    end
                    ph_q <= PhBall;
                end
                PhBall: begin
                    if (st_q == StPlay) begin
                        bx_q <= bx_mv;
                        by_q <= by_nx;
                        dy_q <= dy_nx;
                    end
`ifdef PONG_ATTRACT_EN
                    else if (st_q == StIdle || st_q == StOver) begin
                        bx_q <= bx_nx;
                        dx_q <= dx_nx;
                        by_q <= by_nx;
                        dy_q <= dy_nx;
                    end
`endif
                    ph_q <= PhHit;
                end
                PhHit: begin
                    ph_q       <= PhWait;
                    upd_done_q <= 1'b1;
                    if (st_q == StServe) begin
                        if (cnt_q == CntW'(SERVE_FRAMES - 1)) begin
                            cnt_q <= '0;
                            st_q  <= StPlay;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (st_q == StPlay) begin
                        if (hit_l) begin
                            bx_q <= LHitX;
                            dx_q <= 1'b1;
                        end else if (hit_r) begin
                            bx_q <= RHitX;
                            dx_q <= 1'b0;
                        end else if (bx_q[10]) begin
                            sr_q <= sr_q + 4'd1;
                            bx_q <= CenX;
                            by_q <= CenY;
                            dx_q <= 1'b0;
                            st_q <= (sr_q + 4'd1 == WinS) ? StOver : StServe;
                        end else if (bx_q > MaxX) begin
                            sl_q <= sl_q + 4'd1;
                            bx_q <= CenX;
                            by_q <= CenY;
                            dx_q <= 1'b1;
                            st_q <= (sl_q + 4'd1 == WinS) ? StOver : StServe;
                        end
                    end
                end
            endcase
        end
    end

    assign ball_x_o   = bx_q[9:0];
    assign ball_y_o   = by_q[9:0];
    assign pad_l_y_o  = pl_q;
    assign pad_r_y_o  = pr_q;
    assign score_l_o  = sl_q;
    assign score_r_o  = sr_q;
    assign state_o    = st_q;
    assign upd_done_o = upd_done_q;

endmodule

// File: tb/tb_pong_ctrl.sv
// Bench for pong_ctrl: randomized/steered paddle play checked against a frame-level game model.
module tb_pong_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, frame_tick, serve, l_up, l_dn, r_up, r_dn;
    logic [9:0]  ball_x, ball_y, pad_l_y, pad_r_y;
    logic [3:0]  score_l, score_r;
    logic [1:0]  state;
    logic        upd_done;
    logic [49:0] dut_vec;

    int errors = 0;
    int checks = 0;

    // Game model: positions, directions (+1/-1), scores, state, serve count, last frame event
    int m_st, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_cnt, m_ev;

    always #5 clk = ~clk;

    pong_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .frame_tick_i(frame_tick),
        .serve_i     (serve),
        .l_up_i      (l_up),
        .l_dn_i      (l_dn),
        .r_up_i      (r_up),
        .r_dn_i      (r_dn),
        .ball_x_o    (ball_x),
        .ball_y_o    (ball_y),
        .pad_l_y_o   (pad_l_y),
        .pad_r_y_o   (pad_r_y),
        .score_l_o   (score_l),
        .score_r_o   (score_r),
        .state_o     (state),
        .upd_done_o  (upd_done)
    );

    assign dut_vec = {ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, state};

    function automatic logic [49:0] exp_vec();
        return {10'(m_bx), 10'(m_by), 10'(m_pl), 10'(m_pr), 4'(m_sl), 4'(m_sr), 2'(m_st)};
    endfunction

    function automatic void model_reset();
        m_st = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0; m_cnt = 0; m_ev = 0;
    endfunction

    function automatic void model_serve();
        if (m_st == 3) begin
            m_sl = 0;
            m_sr = 0;
        end
        m_st = 1; m_cnt = 0; m_bx = 316; m_by = 236;
    endfunction

    function automatic int pad_step(input int p, input bit up, input bit dn);
        int t;
        t = p;
        if (up && !dn) t = t - 4;
        else if (dn && !up) t = t + 4;
        if (t < 0) t = 0;
        if (t > 416) t = 416;
        return t;
    endfunction

    function automatic void model_frame(input bit lu, input bit ld, input bit ru, input bit rd);
        m_ev = 0;
        if (m_st == 1 || m_st == 2) begin
            m_pl = pad_step(m_pl, lu, ld);
            m_pr = pad_step(m_pr, ru, rd);
        end
        if (m_st == 1) begin
            m_cnt++;
            if (m_cnt == 60) begin
                m_cnt = 0;
                m_st = 2;
            end
        end else if (m_st == 2) begin
            m_bx = m_bx + 2 * m_dx;
            m_by = m_by + 2 * m_dy;
            if (m_by < 0) begin m_by = 0; m_dy = 1; end
            else if (m_by > 472) begin m_by = 472; m_dy = -1; end
            if (m_dx < 0 && m_bx <= 24 && m_bx + 8 > 16 && m_by + 8 > m_pl && m_by < m_pl + 64) begin
                m_bx = 24; m_dx = 1; m_ev = 1;
            end else if (m_dx > 0 && m_bx + 8 >= 616 && m_bx < 624
                         && m_by + 8 > m_pr && m_by < m_pr + 64) begin
                m_bx = 608; m_dx = -1; m_ev = 2;
            end else if (m_bx < 0) begin
                m_sr++; m_bx = 316; m_by = 236; m_dx = -1; m_ev = 3;
                m_st = (m_sr == 9) ? 3 : 1;
            end else if (m_bx > 632) begin
                m_sl++; m_bx = 316; m_by = 236; m_dx = 1; m_ev = 4;
                m_st = (m_sl == 9) ? 3 : 1;
            end
        end
    endfunction

    // chase: keep the paddle centred on the ball; otherwise run away from it
    function automatic void steer(input int pad, input int by, input bit chase,
                                  output bit up, output bit dn);
        int c;
        c = by + 4 - 32;
        if (chase) begin
            up = (pad > c + 2);
            dn = (pad < c - 2);
        end else if (by + 4 < pad + 32) begin
            up = 1'b0; dn = 1'b1;
        end else begin
            up = 1'b1; dn = 1'b0;
        end
    endfunction

    task automatic do_frame(input bit lu, input bit ld, input bit ru, input bit rd);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        l_up = lu; l_dn = ld; r_up = ru; r_dn = rd;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (upd_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL upd_done_timeout: got no pulse, required one within 8 cycles");
        end
        model_frame(lu, ld, ru, rd);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        model_reset();
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", dut_vec, exp_vec());
        end
        checks++;
        if (upd_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_upd_done: got %b required 0", upd_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: got %h required %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_serve();
        int pulses;
        bit lu, ld, ru, rd;
        do_frame(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL idle_frozen: got %h required %h", dut_vec, exp_vec());
        end
        @(negedge clk);
        serve = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        serve = 1'b0; frame_tick = 1'b0;
        model_serve();
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (upd_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL serve_tick_dropped: got %0d pulses required 0", pulses);
        end
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL serve_state: got %0d required 1", state);
        end
        for (int f = 0; f < 59; f++) begin
            {lu, ld, ru, rd} = 4'($urandom);
            do_frame(lu, ld, ru, rd);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL serve_frame %0d: got %h required %h", f, dut_vec, exp_vec());
            end
        end
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL serve_hold_59: got %0d required 1", state);
        end
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL play_after_60: got %0d required 2", state);
        end
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
            errors++;
            $display("FAIL first_play_move: got (%0d,%0d) required (318,238)", ball_x, ball_y);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL first_play_vec: got %h required %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_paddle_limits();
        for (int f = 0; f < 75; f++) begin
            if (f < 60) do_frame(1'b1, 1'b0, 1'b0, 1'b1);
            else if (f < 70) do_frame(1'b0, 1'b1, 1'($urandom), 1'($urandom));
            else do_frame(1'b1, 1'b1, 1'($urandom), 1'($urandom));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL paddle_frame %0d: got %h required %h", f, dut_vec, exp_vec());
            end
            if (f == 59) begin
                checks++;
                if (pad_l_y !== 10'd0 || pad_r_y !== 10'd416) begin
                    errors++;
                    $display("FAIL pad_clamp: got (%0d,%0d) required (0,416)", pad_l_y, pad_r_y);
                end
            end
        end
        checks++;
        if (pad_l_y !== 10'd40) begin
            errors++;
            $display("FAIL pad_both_pressed: got %0d required 40", pad_l_y);
        end
    endtask

    task automatic test_rally();
        bit lu, ld, ru, rd;
        for (int f = 0; f < 700; f++) begin
            steer(m_pl, m_by, 1'b1, lu, ld);
            steer(m_pr, m_by, 1'b1, ru, rd);
            if ($urandom_range(7) == 0) {lu, ld, ru, rd} = 4'($urandom);
            do_frame(lu, ld, ru, rd);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rally_frame %0d: got %h required %h", f, dut_vec, exp_vec());
            end
            if (m_ev == 1 || m_ev == 2) begin
                checks++;
                if (ball_x !== ((m_ev == 1) ? 10'd24 : 10'd608)) begin
                    errors++;
                    $display("FAIL paddle_hit_x frame %0d: got %0d", f, ball_x);
                end
            end
            if (f == 350 && m_st == 2) begin
                @(negedge clk); serve = 1'b1;
                @(negedge clk); serve = 1'b0;
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL serve_in_play: got %h required %h", dut_vec, exp_vec());
                end
            end
        end
    endtask

    task automatic test_left_miss();
        bit lu, ld, ru, rd, done;
        int prev;
        done = 1'b0;
        prev = m_sr;
        for (int f = 0; f < 1500 && !done; f++) begin
            steer(m_pl, m_by, 1'b0, lu, ld);
            steer(m_pr, m_by, 1'b1, ru, rd);
            do_frame(lu, ld, ru, rd);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL lmiss_frame %0d: got %h required %h", f, dut_vec, exp_vec());
            end
            if (m_ev == 3) done = 1'b1;
        end
        checks++;
        if (!done || score_r !== 4'(prev + 1) || state !== 2'd1 || ball_x !== 10'd316) begin
            errors++;
            $display("FAIL left_miss: got score_r=%0d state=%0d x=%0d required %0d,1,316",
                     score_r, state, ball_x, prev + 1);
        end
    endtask

    task automatic test_win();
        bit lu, ld, ru, rd;
        for (int f = 0; f < 4000 && m_st != 3; f++) begin
            steer(m_pl, m_by, 1'b1, lu, ld);
            steer(m_pr, m_by, 1'b0, ru, rd);
            do_frame(lu, ld, ru, rd);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL win_frame %0d: got %h required %h", f, dut_vec, exp_vec());
            end
        end
        checks++;
        if (score_l !== 4'd9 || state !== 2'd3) begin
            errors++;
            $display("FAIL game_over: got score_l=%0d state=%0d required 9,3", score_l, state);
        end
        do_frame(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL over_hold: got %h required %h", dut_vec, exp_vec());
        end
        @(negedge clk); serve = 1'b1;
        @(negedge clk); serve = 1'b0;
        model_serve();
        checks++;
        if (score_l !== 4'd0 || score_r !== 4'd0 || state !== 2'd1) begin
            errors++;
            $display("FAIL over_serve: got %0d/%0d state=%0d required 0/0 state=1",
                     score_l, score_r, state);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL over_serve_vec: got %h required %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_tick_during_update();
        int pulses;
        pulses = 0;
        @(negedge clk);
        l_up = 1'b0; l_dn = 1'b1; r_up = 1'b1; r_dn = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        if (upd_done === 1'b1) pulses++;
        repeat (8) begin
            @(negedge clk);
            if (upd_done === 1'b1) pulses++;
        end
        model_frame(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL tick_mid_update: got %0d pulses required 1", pulses);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL tick_mid_update_vec: got %h required %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_mid_update();
        int pulses;
        pulses = 0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        model_reset();
        checks++;
        if (dut_vec !== exp_vec() || upd_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_update: got %h/%b required %h/0", dut_vec, upd_done, exp_vec());
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (upd_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_aborted: got %0d pulses %h required 0 pulses %h",
                     pulses, dut_vec, exp_vec());
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; serve = 1'b0;
        l_up = 1'b0; l_dn = 1'b0; r_up = 1'b0; r_dn = 1'b0;
        model_reset();
        test_reset();
        test_serve();
        test_paddle_limits();
        test_rally();
        test_left_miss();
        test_win();
        test_tick_during_update();
        test_reset_mid_update();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
